// File: rtl/sim_status_monitor.sv
// ============================================================================
// Module   : sim_status_monitor
// Brief    : End-of-test monitor: tohost mailbox, watchdog, hang detector,
//            console byte channel, sticky status flags and run counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_status_monitor #(
  parameter int unsigned    XLEN           = 64,
  parameter int unsigned    AW             = 64,
  parameter int unsigned    CNT_W          = 32,
  parameter logic [AW-1:0]  TOHOST_ADDR    = AW'(64'h0000_1000),
  parameter logic [AW-1:0]  CONSOLE_ADDR   = AW'(64'h0000_1008),
  parameter int unsigned    TIMEOUT_CYCLES = 10000,
  parameter int unsigned    HANG_CYCLES    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [AW-1:0]     st_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic              retire_valid,
  output logic              done,
  output logic              done_pulse,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              hang,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic              putc_valid,
  output logic [7:0]        putc_data
);

  localparam bit               c_to_en    = (TIMEOUT_CYCLES != 0);
  localparam bit               c_hang_en  = (HANG_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_to_lim   = c_to_en   ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] c_hang_lim = c_hang_en ? CNT_W'(HANG_CYCLES - 1)    : '0;
  localparam logic [XLEN-1:0]  c_pass_val = XLEN'(1);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PASS    = 3'd1,
    S_FAIL    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_HANG    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             w_in_run;
  logic             w_mbox;
  logic             w_is_pass;
  logic             w_is_fail;
  logic             w_hang_hit;
  logic             w_to_hit;
  logic             w_putc_hit;

  logic             r_done;
  logic             r_done_pulse;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic             r_hang;
  logic [XLEN-2:0]  r_fail_code;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_instret_count;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             r_putc_valid;
  logic [7:0]       r_putc_data;

  assign w_in_run   = (r_state == S_RUN);
  assign w_mbox     = st_valid && (st_addr == TOHOST_ADDR);
  // Even-valued mailbox writes are not end-of-test codes and are ignored.
  assign w_is_pass  = w_mbox && (st_data == c_pass_val);
  assign w_is_fail  = w_mbox && st_data[0] && (st_data != c_pass_val);
  assign w_hang_hit = c_hang_en && !retire_valid && (r_idle_cnt == c_hang_lim);
  assign w_to_hit   = c_to_en && (r_cycle_count == c_to_lim);
  assign w_putc_hit = w_in_run && st_valid && (st_addr == CONSOLE_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_in_run) begin
      if (w_is_pass) begin
        w_next = S_PASS;
      end else if (w_is_fail) begin
        w_next = S_FAIL;
      end else if (w_hang_hit) begin
        w_next = S_HANG;
      end else if (w_to_hit) begin
        w_next = S_TIMEOUT;
      end
    end
  end

  // Flags are only ever set from RUN, so they stay one-hot and sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done          <= 1'b0;
      r_done_pulse    <= 1'b0;
      r_pass          <= 1'b0;
      r_fail          <= 1'b0;
      r_timeout       <= 1'b0;
      r_hang          <= 1'b0;
      r_fail_code     <= '0;
      r_cycle_count   <= '0;
      r_instret_count <= '0;
      r_idle_cnt      <= '0;
      r_putc_valid    <= 1'b0;
      r_putc_data     <= 8'h00;
    end else begin
      r_done_pulse <= w_in_run && (w_next != S_RUN);
      r_putc_valid <= w_putc_hit;
      if (w_putc_hit) begin
        r_putc_data <= st_data[7:0];
      end
      if (w_in_run) begin
        if (r_cycle_count != '1) begin
          r_cycle_count <= r_cycle_count + 1'b1;
        end
        if (retire_valid && (r_instret_count != '1)) begin
          r_instret_count <= r_instret_count + 1'b1;
        end
        if (retire_valid) begin
          r_idle_cnt <= '0;
        end else if (r_idle_cnt != '1) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
        if (w_next != S_RUN) begin
          r_done <= 1'b1;
        end
        if (w_next == S_PASS) begin
          r_pass <= 1'b1;
        end
        if (w_next == S_FAIL) begin
          r_fail      <= 1'b1;
          r_fail_code <= st_data[XLEN-1:1];
        end
        if (w_next == S_TIMEOUT) begin
          r_timeout <= 1'b1;
        end
        if (w_next == S_HANG) begin
          r_hang <= 1'b1;
        end
      end
    end
  end

  assign done          = r_done;
  assign done_pulse    = r_done_pulse;
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign timeout       = r_timeout;
  assign hang          = r_hang;
  assign fail_code     = r_fail_code;
  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
  assign putc_valid    = r_putc_valid;
  assign putc_data     = r_putc_data;

endmodule

`default_nettype wire

// File: tb/tb_sim_status_monitor.sv
// ============================================================================
// Module   : tb_sim_status_monitor
// Brief    : Directed self-checking bench for sim_status_monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sim_status_monitor;

  localparam int c_def = 0;  // default parameters
  localparam int c_to  = 1;  // TIMEOUT_CYCLES=100, hang disabled
  localparam int c_nt  = 2;  // watchdog and hang disabled
  localparam int c_hg  = 3;  // HANG_CYCLES=8, watchdog disabled

  localparam logic [63:0] c_tohost  = 64'h1000;
  localparam logic [63:0] c_console = 64'h1008;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        retire_valid;

  logic        w_done       [4];
  logic        w_done_pulse [4];
  logic        w_pass       [4];
  logic        w_fail       [4];
  logic        w_timeout    [4];
  logic        w_hang       [4];
  logic [62:0] w_fail_code  [4];
  logic [31:0] w_cycle      [4];
  logic [31:0] w_instret    [4];
  logic        w_putc_valid [4];
  logic [7:0]  w_putc_data  [4];

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_status_monitor u_dut_def (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire_valid(retire_valid), .done(w_done[c_def]), .done_pulse(w_done_pulse[c_def]),
    .pass(w_pass[c_def]), .fail(w_fail[c_def]), .timeout(w_timeout[c_def]),
    .hang(w_hang[c_def]), .fail_code(w_fail_code[c_def]), .cycle_count(w_cycle[c_def]),
    .instret_count(w_instret[c_def]), .putc_valid(w_putc_valid[c_def]),
    .putc_data(w_putc_data[c_def])
  );

  sim_status_monitor #(.TIMEOUT_CYCLES(100), .HANG_CYCLES(0)) u_dut_to (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire_valid(retire_valid), .done(w_done[c_to]), .done_pulse(w_done_pulse[c_to]),
    .pass(w_pass[c_to]), .fail(w_fail[c_to]), .timeout(w_timeout[c_to]),
    .hang(w_hang[c_to]), .fail_code(w_fail_code[c_to]), .cycle_count(w_cycle[c_to]),
    .instret_count(w_instret[c_to]), .putc_valid(w_putc_valid[c_to]),
    .putc_data(w_putc_data[c_to])
  );

  sim_status_monitor #(.TIMEOUT_CYCLES(0), .HANG_CYCLES(0)) u_dut_nt (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire_valid(retire_valid), .done(w_done[c_nt]), .done_pulse(w_done_pulse[c_nt]),
    .pass(w_pass[c_nt]), .fail(w_fail[c_nt]), .timeout(w_timeout[c_nt]),
    .hang(w_hang[c_nt]), .fail_code(w_fail_code[c_nt]), .cycle_count(w_cycle[c_nt]),
    .instret_count(w_instret[c_nt]), .putc_valid(w_putc_valid[c_nt]),
    .putc_data(w_putc_data[c_nt])
  );

  sim_status_monitor #(.TIMEOUT_CYCLES(0), .HANG_CYCLES(8)) u_dut_hg (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .retire_valid(retire_valid), .done(w_done[c_hg]), .done_pulse(w_done_pulse[c_hg]),
    .pass(w_pass[c_hg]), .fail(w_fail[c_hg]), .timeout(w_timeout[c_hg]),
    .hang(w_hang[c_hg]), .fail_code(w_fail_code[c_hg]), .cycle_count(w_cycle[c_hg]),
    .instret_count(w_instret[c_hg]), .putc_valid(w_putc_valid[c_hg]),
    .putc_data(w_putc_data[c_hg])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One RUN cycle: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic sv, input logic [63:0] a, input logic [63:0] d,
                     input logic rv);
    st_valid     = sv;
    st_addr      = a;
    st_data      = d;
    retire_valid = rv;
    @(posedge clk);
    #1;
    st_valid     = 1'b0;
    retire_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    st_valid     = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    retire_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Retires in cycles 1..10, then idle cycles up to and including 'last'.
  task automatic retire_then_idle(input int last);
    for (int c = 1; c <= last; c++) begin
      cyc(1'b0, '0, '0, (c <= 10));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    retire_valid = 1'b0;
    @(posedge clk);
    do_reset();

    check("rst_done",    64'(w_done[c_def]), 64'd0);
    check("rst_pulse",   64'(w_done_pulse[c_def]), 64'd0);
    check("rst_flags",   64'({w_pass[c_def], w_fail[c_def], w_timeout[c_def], w_hang[c_def]}), 64'd0);
    check("rst_cycle",   64'(w_cycle[c_def]), 64'd0);
    check("rst_instret", 64'(w_instret[c_def]), 64'd0);
    check("rst_putc",    64'(w_putc_valid[c_def]), 64'd0);

    // PASS at RUN cycle 20 with 15 retires.
    for (int c = 1; c <= 19; c++) begin
      cyc(1'b0, '0, '0, (c <= 15));
    end
    check("pre_pass_done", 64'(w_done[c_def]), 64'd0);
    cyc(1'b1, c_tohost, 64'd1, 1'b0);
    check("pass_flag",    64'(w_pass[c_def]), 64'd1);
    check("pass_done",    64'(w_done[c_def]), 64'd1);
    check("pass_pulse",   64'(w_done_pulse[c_def]), 64'd1);
    check("pass_cycle",   64'(w_cycle[c_def]), 64'd20);
    check("pass_instret", 64'(w_instret[c_def]), 64'd15);
    check("pass_nofail",  64'(w_fail[c_def]), 64'd0);
    cyc(1'b1, c_tohost, 64'd7, 1'b1);
    check("pass_pulse_end", 64'(w_done_pulse[c_def]), 64'd0);
    check("pass_sticky",    64'(w_pass[c_def]), 64'd1);
    check("pass_fail_blk",  64'(w_fail[c_def]), 64'd0);
    check("pass_cyc_frz",   64'(w_cycle[c_def]), 64'd20);
    check("pass_ins_frz",   64'(w_instret[c_def]), 64'd15);

    // Reset in PASS clears everything, run restarts.
    do_reset();
    check("rerst_pass",  64'(w_pass[c_def]), 64'd0);
    check("rerst_done",  64'(w_done[c_def]), 64'd0);
    check("rerst_cycle", 64'(w_cycle[c_def]), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    check("restart_cycle", 64'(w_cycle[c_def]), 64'd1);

    // Even mailbox value ignored, then FAIL with code 3.
    cyc(1'b1, c_tohost, 64'd4, 1'b0);
    check("even_ignored", 64'(w_done[c_def]), 64'd0);
    cyc(1'b1, c_tohost, 64'd7, 1'b0);
    check("fail_flag",  64'(w_fail[c_def]), 64'd1);
    check("fail_code",  64'(w_fail_code[c_def]), 64'd3);
    check("fail_nopass", 64'(w_pass[c_def]), 64'd0);
    check("fail_cycle", 64'(w_cycle[c_def]), 64'd3);

    // Console: back-to-back bytes, then suppression after done.
    do_reset();
    cyc(1'b1, c_console, 64'h48, 1'b0);
    check("putc0_v", 64'(w_putc_valid[c_def]), 64'd1);
    check("putc0_d", 64'(w_putc_data[c_def]), 64'h48);
    cyc(1'b1, c_console, 64'h69, 1'b0);
    check("putc1_v", 64'(w_putc_valid[c_def]), 64'd1);
    check("putc1_d", 64'(w_putc_data[c_def]), 64'h69);
    cyc(1'b0, '0, '0, 1'b0);
    check("putc_idle", 64'(w_putc_valid[c_def]), 64'd0);
    cyc(1'b1, c_tohost, 64'd1, 1'b0);
    cyc(1'b1, c_console, 64'h58, 1'b0);
    check("putc_after_done", 64'(w_putc_valid[c_def]), 64'd0);

    // Watchdog: retire every cycle, no mailbox writes.
    do_reset();
    for (int c = 1; c <= 99; c++) begin
      cyc(1'b0, '0, '0, 1'b1);
    end
    check("to_early", 64'(w_timeout[c_to]), 64'd0);
    cyc(1'b0, '0, '0, 1'b1);
    check("to_flag",  64'(w_timeout[c_to]), 64'd1);
    check("to_cycle", 64'(w_cycle[c_to]), 64'd100);
    check("to_pulse", 64'(w_done_pulse[c_to]), 64'd1);
    for (int c = 101; c <= 1000; c++) begin
      cyc(1'b0, '0, '0, 1'b1);
    end
    check("to_cyc_frz",   64'(w_cycle[c_to]), 64'd100);
    check("nt_notimeout", 64'(w_timeout[c_nt]), 64'd0);
    check("nt_notdone",   64'(w_done[c_nt]), 64'd0);
    check("nt_cycle",     64'(w_cycle[c_nt]), 64'd1000);

    // Hang: retires stop after cycle 10.
    do_reset();
    retire_then_idle(17);
    check("hang_early", 64'(w_hang[c_hg]), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    check("hang_flag",    64'(w_hang[c_hg]), 64'd1);
    check("hang_instret", 64'(w_instret[c_hg]), 64'd10);
    check("hang_cycle",   64'(w_cycle[c_hg]), 64'd18);

    // Retire at idle 7 cancels; the next idle run of 8 hangs at cycle 26.
    do_reset();
    retire_then_idle(17);
    cyc(1'b0, '0, '0, 1'b1);
    check("hang_cancel", 64'(w_hang[c_hg]), 64'd0);
    for (int c = 19; c <= 25; c++) begin
      cyc(1'b0, '0, '0, 1'b0);
    end
    check("hang2_early", 64'(w_hang[c_hg]), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    check("hang2_flag", 64'(w_hang[c_hg]), 64'd1);

    // Pass and hang in the same cycle: pass wins.
    do_reset();
    retire_then_idle(17);
    cyc(1'b1, c_tohost, 64'd1, 1'b0);
    check("prio_pass", 64'(w_pass[c_hg]), 64'd1);
    check("prio_hang", 64'(w_hang[c_hg]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
